// File: rtl/mem_arb_pkg.sv
// Shared definitions for the SRAM port arbiter.
//   arb_state_e      : arbiter FSM state encoding
//   BE_WORD/BE_NONE  : active-low byte-enable patterns (all lanes / no lanes)
//   ADDR_HI/ADDR_LO  : byte-address slice that forms the SRAM word address
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_W_SETUP = 3'd2,
    ST_W_PULSE = 3'd3,
    ST_W_HOLD  = 3'd4,
    ST_DONE    = 3'd5
  } arb_state_e;

  localparam logic [3:0] BE_WORD = 4'h0;
  localparam logic [3:0] BE_NONE = 4'hF;

  localparam int ADDR_HI = 21;
  localparam int ADDR_LO = 2;
  localparam int MEM_AW  = ADDR_HI - ADDR_LO + 1;

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane steering for one SRAM access.
//   addr_lo   : byte offset within the word (ignored for word accesses)
//   is_byte   : 1 = byte access, 0 = word access
//   wdata     : store data from the requester
//   rdata     : raw word from the SRAM
//   be_n      : active-low byte enables
//   wdata_rep : store data as it goes on the bus (byte replicated to all lanes)
//   rdata_ext : load result (selected byte sign-extended, or the full word)
module byte_lane_unit
  import mem_arb_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic        is_byte,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be_n,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0] sel_byte;

  always_comb begin
    be_n      = BE_WORD;
    wdata_rep = wdata;
    rdata_ext = rdata;
    sel_byte  = rdata[{addr_lo, 3'b000} +: 8];
    if (is_byte) begin
      be_n      = ~(4'b0001 << addr_lo);
      wdata_rep = {4{wdata[7:0]}};
      rdata_ext = {{24{sel_byte[7]}}, sel_byte};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Sequences the single SRAM port between instruction fetch and MEM-stage data
// accesses, with setup/strobe/hold timing, lane steering and a pipeline stall.
//   clk, rst          : clock, asynchronous active-low reset
//   if_req/if_addr    : fetch request and byte address
//   if_ack/if_rdata   : fetch completion pulse and fetched word
//   d_req/d_we/d_byte : data request, store select, byte-size select
//   d_addr/d_wdata    : data byte address and store data
//   d_ack/d_rdata     : data completion pulse and load result
//   stall_o           : pipeline stall while any request is outstanding
//   mem_*             : SRAM address, active-low strobes, write data/drive
//   dbg_state         : current FSM state for observation
//
// Handshake: a requester raises req with its address/data stable and keeps them
// stable until it sees ack (a single-cycle pulse). A req still high in the cycle
// after ack is a new request. Requests are only arbitrated in IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_WAIT    = 1,
  parameter int WR_WAIT    = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              stall_o,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_be_n,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic [31:0]       mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        dbg_state
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
  localparam logic [7:0] RD_LAST = 8'(RD_WAIT - 1);
  localparam logic [7:0] WR_LAST = 8'(WR_WAIT - 1);

  arb_state_e          state_q, state_d;
  logic [7:0]          wait_cnt;
  logic [STREAK_W-1:0] streak;
  logic                grant_d, grant_i;

  // Latched access descriptor; lat_data selects which requester owns the access.
  logic [ADDR_HI:0]    lat_addr;
  logic [31:0]         lat_wdata;
  logic                lat_we, lat_byte, lat_data;
  logic [31:0]         rdata_q;

  logic [3:0]          lane_be_n;
  logic [31:0]         lane_wdata, lane_rdata;

  // Upper address bits never reach the SRAM.
  logic                unused_addr_hi;
  assign unused_addr_hi = ^{if_addr[31:ADDR_HI+1], d_addr[31:ADDR_HI+1]};

  byte_lane_unit u_lane (
    .addr_lo   (lat_addr[1:0]),
    .is_byte   (lat_byte),
    .wdata     (lat_wdata),
    .rdata     (mem_rdata),
    .be_n      (lane_be_n),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  // Data wins unless a fetch is waiting and data already had MAX_STREAK turns.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state_q == ST_IDLE) begin
      grant_d = d_req && (!if_req || (streak < STREAK_MAX));
      grant_i = !grant_d && if_req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_ce_n     = 1'b1;
    mem_oe_n     = 1'b1;
    mem_we_n     = 1'b1;
    mem_wdata_oe = 1'b0;
    mem_be_n     = BE_NONE;
    mem_wdata    = 32'h0;
    if_ack       = 1'b0;
    d_ack        = 1'b0;
    if_rdata     = 32'h0;
    d_rdata      = 32'h0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_d)      state_d = d_we ? ST_W_SETUP : ST_READ;
        else if (grant_i) state_d = ST_READ;
      end
      ST_READ: begin
        mem_ce_n = 1'b0;
        mem_oe_n = 1'b0;
        mem_be_n = lane_be_n;
        if (wait_cnt == RD_LAST) state_d = ST_DONE;
      end
      ST_W_SETUP, ST_W_PULSE, ST_W_HOLD: begin
        mem_ce_n     = 1'b0;
        mem_wdata_oe = 1'b1;
        mem_be_n     = lane_be_n;
        mem_wdata    = lane_wdata;
        if (state_q == ST_W_SETUP) state_d = ST_W_PULSE;
        if (state_q == ST_W_HOLD)  state_d = ST_DONE;
        if (state_q == ST_W_PULSE) begin
          mem_we_n = 1'b0;
          if (wait_cnt == WR_LAST) state_d = ST_W_HOLD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (lat_data) begin
          d_ack = 1'b1;
          if (!lat_we) d_rdata = rdata_q;
        end else begin
          if_ack   = 1'b1;
          if_rdata = rdata_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      streak    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_byte  <= 1'b0;
      lat_data  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      // Counts cycles spent in a multi-cycle strobe state; restarts on entry.
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (state_q == ST_READ || state_q == ST_W_PULSE)
        wait_cnt <= wait_cnt + 8'd1;

      if (grant_d) begin
        lat_addr  <= d_addr[ADDR_HI:0];
        lat_wdata <= d_wdata;
        lat_we    <= d_we;
        lat_byte  <= d_byte;
        lat_data  <= 1'b1;
        if (!if_req)                  streak <= '0;
        else if (streak != STREAK_MAX) streak <= streak + 1'b1;
      end else if (grant_i) begin
        lat_addr  <= if_addr[ADDR_HI:0];
        lat_wdata <= '0;
        lat_we    <= 1'b0;
        lat_byte  <= 1'b0;
        lat_data  <= 1'b0;
        streak    <= '0;
      end

      if (state_q == ST_READ && wait_cnt == RD_LAST) rdata_q <= lane_rdata;
    end
  end

  assign mem_addr  = lat_addr[ADDR_HI:ADDR_LO];
  assign stall_o   = (if_req & ~if_ack) | (d_req & ~d_ack);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int RD_WAIT    = 1;
  localparam int WR_WAIT    = 2;
  localparam int MAX_STREAK = 4;
  localparam int RD_DONE    = RD_WAIT + 1;
  localparam int WR_DONE    = WR_WAIT + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_byte = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        stall_o;
  logic [19:0] mem_addr;
  logic [3:0]  mem_be_n;
  logic        mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [2:0]  dbg_state;

  mem_arbiter #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .stall_o(stall_o),
    .mem_addr(mem_addr), .mem_be_n(mem_be_n), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n),
    .mem_we_n(mem_we_n), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An access is described by its offset k (cycles since the grant cycle).
  // Reads: strobes for k=1..RD_WAIT, ack at RD_WAIT+1.
  // Writes: setup k=1, we pulse k=2..WR_WAIT+1, hold WR_WAIT+2, ack WR_WAIT+3.
  logic [3:0]  be_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  bit          m_busy = 0, m_data = 0, m_we = 0, m_byte = 0;
  int          m_k = 0, m_streak = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rd = '0;
  logic [31:0] m_grants[$];

  always @(negedge clk) begin
    bit          wr_kind, e_rd, e_wr, e_pulse, e_ack;
    logic [3:0]  e_be;
    logic [7:0]  b;
    logic [31:0] e_rdata;
    if (!rst) begin
      m_busy = 0; m_k = 0; m_streak = 0;
    end
    wr_kind = m_data && m_we;
    e_rd    = m_busy && !wr_kind && (m_k <= RD_WAIT);
    e_wr    = m_busy && wr_kind && (m_k <= WR_WAIT + 2);
    e_pulse = m_busy && wr_kind && (m_k >= 2) && (m_k <= WR_WAIT + 1);
    e_ack   = m_busy && (m_k == (wr_kind ? WR_DONE : RD_DONE));
    e_be    = m_byte ? be_tab[m_addr[1:0]] : 4'h0;
    if (e_rd && m_k == RD_WAIT) m_rd = mem_rdata;
    b       = m_rd[8*m_addr[1:0] +: 8];
    e_rdata = m_byte ? {{24{b[7]}}, b} : m_rd;

    chk("ce_n", 32'(mem_ce_n), 32'(!(e_rd || e_wr)));
    chk("oe_n", 32'(mem_oe_n), 32'(!e_rd));
    chk("we_n", 32'(mem_we_n), 32'(!e_pulse));
    chk("wdata_oe", 32'(mem_wdata_oe), 32'(e_wr));
    chk("be_n", 32'(mem_be_n), 32'((e_rd || e_wr) ? e_be : 4'hF));
    chk("if_ack", 32'(if_ack), 32'(e_ack && !m_data));
    chk("d_ack", 32'(d_ack), 32'(e_ack && m_data));
    chk("stall", 32'(stall_o),
        32'((if_req && !(e_ack && !m_data)) || (d_req && !(e_ack && m_data))));
    if (e_rd || e_wr) chk("mem_addr", 32'(mem_addr), 32'(m_addr[21:2]));
    if (e_wr) chk("mem_wdata", mem_wdata, m_byte ? {4{m_wdata[7:0]}} : m_wdata);
    if (e_ack && !wr_kind && m_data)  chk("d_rdata", d_rdata, e_rdata);
    if (e_ack && !wr_kind && !m_data) chk("if_rdata", if_rdata, e_rdata);
    if (!rst) begin
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
    end

    if (rst) begin
      if (m_busy) begin
        if (e_ack) m_busy = 0;
        else       m_k++;
      end else if (d_req && (!if_req || m_streak < MAX_STREAK)) begin
        m_busy = 1; m_k = 1; m_data = 1;
        m_we = d_we; m_byte = d_byte; m_addr = d_addr; m_wdata = d_wdata;
        m_streak = if_req ? ((m_streak < MAX_STREAK) ? m_streak + 1 : m_streak) : 0;
        m_grants.push_back(32'd1);
      end else if (if_req) begin
        m_busy = 1; m_k = 1; m_data = 0;
        m_we = 0; m_byte = 0; m_addr = if_addr; m_wdata = '0;
        m_streak = 0;
        m_grants.push_back(32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] rd,
                         input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_byte = 1; d_addr = a; mem_rdata = rd;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_ack"}, 32'(d_ack), 32'd1);
    chk({nm, "_rdata"}, d_rdata, exp);
    @(posedge clk); #1;
    d_req = 0; d_byte = 0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] ord [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    int  acks;
    bit  ia, da;
    logic [31:0] e;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_ce_n", 32'(mem_ce_n), 32'd1);
    chk("rst_oe_n", 32'(mem_oe_n), 32'd1);
    chk("rst_we_n", 32'(mem_we_n), 32'd1);
    chk("rst_be_n", 32'(mem_be_n), 32'hF);
    chk("rst_wdata_oe", 32'(mem_wdata_oe), 32'd0);
    @(posedge clk); #1;
    rst = 1;
    idle_cycle();

    // Fetch
    if_req = 1; if_addr = 32'h80000004; mem_rdata = 32'h3C011234;
    @(negedge clk);
    chk("stall_t", 32'(stall_o), 32'd1);
    @(negedge clk);
    chk("fetch_addr", 32'(mem_addr), 32'h00001);
    chk("fetch_oe_n", 32'(mem_oe_n), 32'd0);
    chk("stall_t1", 32'(stall_o), 32'd1);
    @(negedge clk);
    chk("fetch_ack", 32'(if_ack), 32'd1);
    chk("fetch_rdata", if_rdata, 32'h3C011234);
    chk("stall_t2", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    if_req = 0;
    idle_cycle();

    // Byte store
    d_req = 1; d_we = 1; d_byte = 1; d_addr = 32'h80000103; d_wdata = 32'h000000A5;
    @(negedge clk);
    @(negedge clk);
    chk("st_be_n", 32'(mem_be_n), 32'h7);
    chk("st_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("st_we_setup", 32'(mem_we_n), 32'd1);
    @(negedge clk);
    chk("st_we_p0", 32'(mem_we_n), 32'd0);
    @(negedge clk);
    chk("st_we_p1", 32'(mem_we_n), 32'd0);
    @(negedge clk);
    chk("st_we_hold", 32'(mem_we_n), 32'd1);
    chk("st_no_early_ack", 32'(d_ack), 32'd0);
    @(negedge clk);
    chk("st_ack", 32'(d_ack), 32'd1);
    @(posedge clk); #1;
    d_req = 0; d_we = 0; d_byte = 0;
    idle_cycle();

    // Byte loads
    do_load(32'h80000002, 32'h12F45678, 32'hFFFFFFF4, "ldb2");
    idle_cycle();
    do_load(32'h80000001, 32'h12F45678, 32'h00000056, "ldb1");
    idle_cycle();
    @(negedge clk);
    chk("stall_idle", 32'(stall_o), 32'd0);

    // Contention: both requests held high
    m_grants.delete();
    foreach (ord[i]) exp_q.push_back(ord[i]);
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h80000010;
    d_req = 1; d_we = 0; d_byte = 0; d_addr = 32'h80000020; mem_rdata = 32'hCAFEF00D;
    acks = 0;
    for (int c = 0; c < 200 && acks < 10; c++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        acks++;
        if (exp_q.size() == 0) chk("grant_extra", 32'(acks), 32'd10);
        else begin
          e = exp_q.pop_front();
          chk("grant_order", 32'(d_ack), e);
        end
      end
    end
    chk("contention_acks", 32'(acks), 32'd10);
    @(posedge clk); #1;
    if_req = 0; d_req = 0;
    chk("model_grants_n", 32'(m_grants.size()), 32'd10);
    for (int i = 0; i < 10 && i < m_grants.size(); i++)
      chk("model_grant_order", m_grants[i], ord[i]);
    idle_cycle();

    // Reset during the write pulse
    d_req = 1; d_we = 1; d_byte = 0; d_addr = 32'h80000040; d_wdata = 32'h11223344;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rw_pulse_we", 32'(mem_we_n), 32'd0);
    #2;
    rst = 0; d_req = 0; d_we = 0;
    #1;
    chk("rw_we_n", 32'(mem_we_n), 32'd1);
    chk("rw_ce_n", 32'(mem_ce_n), 32'd1);
    chk("rw_be_n", 32'(mem_be_n), 32'hF);
    chk("rw_wdata_oe", 32'(mem_wdata_oe), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rw_no_ack", 32'(d_ack), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rw_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("rw_no_ack_after", 32'(d_ack), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      ia = if_ack; da = d_ack;
      @(posedge clk); #1;
      if (!if_req || ia) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = $urandom;
      end
      if (!d_req || da) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_byte  = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      mem_rdata = $urandom;
    end

    // Drain: let outstanding requests finish, issue no new ones
    for (int c = 0; c < 50 && (if_req || d_req); c++) begin
      @(negedge clk);
      ia = if_ack; da = d_ack;
      @(posedge clk); #1;
      if (ia) if_req = 0;
      if (da) d_req = 0;
    end
    chk("drain_done", 32'(if_req || d_req), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared SRAM port between the instruction-fetch requester and the MEM-stage data requester.
- Replaces the combinational priority mux currently in front of the MMU.
- Gives each access a multi-cycle SRAM timing with setup, strobe and hold phases.
- Produces per-requester acknowledges and a pipeline stall.
- Handles byte and word lane steering for loads and stores.

Parameters:
RD_WAIT, 1, cycles oe_n held low before read data is captured (>=1)
WR_WAIT, 2, cycles we_n held low per write (>=1)
MAX_STREAK, 4, maximum consecutive data grants while a fetch is waiting

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held until if_ack
if_addr  in  32  fetch byte address
if_ack  out  1  one-cycle pulse: fetch complete
if_rdata  out  32  fetch word, valid while if_ack=1
d_req  in  1  data request; held until d_ack
d_we  in  1  1=store, 0=load
d_byte  in  1  1=byte access, 0=word access
d_addr  in  32  data byte address
d_wdata  in  32  store data (byte taken from [7:0])
d_ack  out  1  one-cycle pulse: data access complete
d_rdata  out  32  load result, valid while d_ack=1
stall_o  out  1  pipeline stall
mem_addr  out  20  SRAM word address = addr[21:2]
mem_be_n  out  4  SRAM byte enables, active low
mem_ce_n  out  1  SRAM chip enable, active low
mem_oe_n  out  1  SRAM output enable, active low
mem_we_n  out  1  SRAM write enable, active low
mem_wdata  out  32  SRAM write data
mem_wdata_oe  out  1  tristate drive enable for the data bus
mem_rdata  in  32  SRAM read data

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; streak counter cleared.
  - if_ack=d_ack=0; if_rdata=d_rdata=0.
  - mem_ce_n=mem_oe_n=mem_we_n=1; mem_be_n=4'hF; mem_wdata_oe=0; mem_addr=0; mem_wdata=0.
  - A reset mid-access abandons the access: no ack is issued, and strobes deassert immediately.
- States: IDLE, READ, W_SETUP, W_PULSE, W_HOLD, DONE.
- IDLE arbitration, evaluated each cycle:
  - Data is granted if d_req && (!if_req || streak<MAX_STREAK); otherwise fetch is granted if if_req.
  - Streak counter: incremented (saturating) on a data grant while if_req=1; cleared on a data grant while if_req=0; cleared on a fetch grant.
  - On grant, the granted requester's address/we/byte/wdata are latched into internal registers. Next state is READ for fetches and loads, W_SETUP for stores.
- READ:
  - ce_n=0, oe_n=0, be_n per lane rule below.
  - Stays RD_WAIT cycles; on the last cycle mem_rdata is captured and lane-extracted, then the FSM goes to DONE.
- W_SETUP: 1 cycle; ce_n=0, we_n=1, mem_wdata_oe=1, address/data/be_n valid.
- W_PULSE: WR_WAIT cycles with we_n=0.
- W_HOLD: 1 cycle with we_n=1; data and address still driven.
- DONE:
  - The granted requester's ack is high for exactly one cycle.
  - For fetches and loads, the captured data is presented on rdata.
  - All strobes are high. Requests are not sampled in this cycle; next state is IDLE.
- Latency, with the grant in cycle t:
  - Read ack in cycle t+RD_WAIT+1 (t+2 at default).
  - Write ack in cycle t+WR_WAIT+3 (t+5 at default).
- Lane rules:
  - Fetches and word accesses: be_n=4'h0; addr[1:0] ignored (forced word-aligned).
  - Byte accesses: be_n=~(4'b0001<<addr[1:0]); store data is replicated as {4{wdata[7:0]}}.
  - Byte loads: return byte addr[1:0] of mem_rdata, sign-extended to 32 bits.
- stall_o = (if_req & ~if_ack) | (d_req & ~d_ack), combinational.
- A requester that drops req before its ack is a protocol violation. The access in flight completes and the ack is still pulsed.
- Between accesses, mem_wdata_oe is 0 in every state except W_SETUP, W_PULSE and W_HOLD.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding constants;
  - the lane constants BE_WORD=4'h0 and BE_NONE=4'hF;
  - the address slice bounds 21:2.
- One combinational sub-module, byte_lane_unit. Inputs: addr[1:0], byte, wdata, rdata. Outputs: be_n, replicated wdata, extracted/extended rdata.

Test Plan:
- Fetch: if_req=1, if_addr=0x80000004, mem_rdata=0x3C011234 -> mem_addr=0x00001 with oe_n=0 in t+1, if_ack=1 and if_rdata=0x3C011234 in t+2.
- Byte store: d_addr=0x80000103, d_wdata=0x000000A5 -> be_n=4'b0111, mem_wdata=0xA5A5A5A5, we_n=0 in t+2..t+3 only, d_ack in t+5.
- Byte load: d_addr=0x80000002, mem_rdata=0x12F45678 -> d_rdata=0xFFFFFFF4; the same load at offset 1 (byte 0x56) -> d_rdata=0x00000056.
- Contention: if_req and d_req held high continuously, MAX_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; no fetch waits more than 4 data accesses.
- Reset mid-write: rst=0 asserted asynchronously during W_PULSE -> we_n, ce_n and be_n go high in the same cycle without a clock edge; d_ack is never pulsed; after release, the FSM is in IDLE.
- Stall: if_req high from t -> stall_o=1 in t and t+1, 0 in t+2 (ack cycle); with both requests idle, stall_o=0.
